// File: rtl/adc_spi_slave_mc.sv
// adc_spi_slave_mc: multi-channel SPI mode-0 register slave for the SAR ADC.
// Ports: clk/reset_, SPI cs/sck/mosi/miso, adc_data_in/adc_busy_in/
//   adc_eoc_pulse/hw_clear_start per channel; ctrl_reg_out, eoc_flag_out,
//   overrun_out, irq_out. Option macro ADC_SPI_BURST_EN: DATA burst reads.
module adc_spi_slave_mc #(
    parameter int          DATA_W  = 12,
    parameter int          NUM_CH  = 4,
    parameter int          ADDR_W  = 4,
    parameter logic [7:0]  INFO_ID = 8'h0B
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       cs,
    input  logic                       sck,
    input  logic                       mosi,
    output logic                       miso,
    input  logic [NUM_CH*DATA_W-1:0]   adc_data_in,
    input  logic [NUM_CH-1:0]          adc_busy_in,
    input  logic [NUM_CH-1:0]          adc_eoc_pulse,
    input  logic [NUM_CH-1:0]          hw_clear_start,
    output logic [DATA_W-1:0]          ctrl_reg_out,
    output logic [NUM_CH-1:0]          eoc_flag_out,
    output logic [NUM_CH-1:0]          overrun_out,
    output logic                       irq_out
);
    localparam int F   = 2 + ADDR_W + DATA_W;
    localparam int HDR = 2 + ADDR_W;
    localparam int CW  = $clog2(F + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_SET = 2'b10;
    localparam logic [1:0] CMD_CLR = 2'b11;

`ifdef ADC_SPI_BURST_EN
    localparam int WW = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_BURST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;
`endif

    // cs is synchronised alongside sck so their relative order is kept
    logic [2:0]        sck_q;
    logic [1:0]        mosi_q;
    logic [1:0]        cs_q;
    logic [NUM_CH-1:0] eoc_q1, eoc_q2, eoc_q3;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sck_q  <= '0;
            mosi_q <= '0;
            cs_q   <= 2'b11;
            eoc_q1 <= '0;
            eoc_q2 <= '0;
            eoc_q3 <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            mosi_q <= {mosi_q[0], mosi};
            cs_q   <= {cs_q[0], cs};
            eoc_q1 <= adc_eoc_pulse;
            eoc_q2 <= eoc_q1;
            eoc_q3 <= eoc_q2;
        end
    end

    logic              sck_rise, sck_fall, cs_s, mosi_s;
    logic [NUM_CH-1:0] eoc_rise;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_s     = cs_q[1];
    assign mosi_s   = mosi_q[1];
    assign eoc_rise = eoc_q2 & ~eoc_q3;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [F-1:0]       sh;
    logic [DATA_W-1:0]  mbuf;
    logic               done;
    logic [CHW-1:0]     rd_ch;
    logic [NUM_CH-1:0]  eoc_sent;

    logic [DATA_W-1:0]  ctrl_r;
    logic [NUM_CH-1:0]  eoc_r;
    logic [NUM_CH-1:0]  ovr_r;
    logic [DATA_W-1:0]  data_r [NUM_CH];

    // header fields as seen at preload time (low bits of the shifter)
    logic [1:0]         hdr_cmd;
    logic [ADDR_W-1:0]  hdr_addr;
    // full-frame fields as seen in LATCH
    logic [1:0]         lat_cmd;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_pay;

    assign hdr_cmd  = sh[ADDR_W +: 2];
    assign hdr_addr = sh[ADDR_W-1:0];
    assign lat_cmd  = sh[F-1 -: 2];
    assign lat_addr = sh[DATA_W +: ADDR_W];
    assign lat_pay  = sh[DATA_W-1:0];

    logic [DATA_W-1:0]  rd_val;
    logic [CHW-1:0]     hdr_ch;
    logic               lat_is_data;

    always_comb begin
        rd_val      = '0;
        hdr_ch      = '0;
        lat_is_data = 1'b0;
        if (hdr_addr == ADDR_W'(0))
            rd_val = ctrl_r;
        else if (hdr_addr == ADDR_W'(1))
            rd_val[2*NUM_CH-1:0] = {ovr_r, eoc_r};
        else if (hdr_addr == ADDR_W'(2))
            rd_val[NUM_CH-1:0] = adc_busy_in;
        else if (hdr_addr == ADDR_W'(3))
            rd_val[11:0] = {4'(NUM_CH), INFO_ID};
        for (int c = 0; c < NUM_CH; c++) begin
            if (hdr_addr == ADDR_W'(4 + c)) begin
                rd_val = data_r[c];
                hdr_ch = CHW'(c);
            end
            if (lat_addr == ADDR_W'(4 + c))
                lat_is_data = 1'b1;
        end
    end

    logic in_latch;
    assign in_latch = (state == S_LATCH);

    logic [NUM_CH-1:0] burst_clr;

`ifdef ADC_SPI_BURST_EN
    logic [CHW-1:0] bch;
    logic [CHW-1:0] nxt;
    logic [WW-1:0]  wcnt;
    logic           wend;

    assign nxt = (bch == CHW'(NUM_CH - 1)) ? '0 : bch + CHW'(1);

    always_comb begin
        burst_clr = '0;
        if (state == S_BURST && !cs_s && sck_rise &&
            wcnt == WW'(DATA_W - 1))
            burst_clr[bch] = 1'b1;
    end
`else
    assign burst_clr = '0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '0;
            mbuf     <= '0;
            done     <= 1'b0;
            rd_ch    <= '0;
            eoc_sent <= '0;
`ifdef ADC_SPI_BURST_EN
            bch      <= '0;
            wcnt     <= '0;
            wend     <= 1'b0;
`endif
        end else begin
            if (!cs_s && sck_fall)
                mbuf <= {mbuf[DATA_W-2:0], 1'b0};
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // done blocks a second frame until cs has gone high
                    if (cs_s)
                        done <= 1'b0;
                    else if (!done)
                        state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cs_s) begin
                        state <= S_IDLE;
                    end else begin
                        if (sck_rise) begin
                            sh  <= {sh[F-2:0], mosi_s};
                            cnt <= cnt + CW'(1);
                            if (cnt == CW'(F - 1))
                                state <= S_LATCH;
                        end
                        if (sck_fall && cnt == CW'(HDR)) begin
                            mbuf <= (hdr_cmd == CMD_RD) ? rd_val : '0;
                            if (hdr_cmd == CMD_RD) begin
                                rd_ch <= hdr_ch;
                                if (hdr_addr == ADDR_W'(1))
                                    eoc_sent <= eoc_r;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
`ifdef ADC_SPI_BURST_EN
                    if (lat_cmd == CMD_RD && lat_is_data && !cs_s) begin
                        state <= S_BURST;
                        bch   <= rd_ch;
                        wcnt  <= '0;
                        wend  <= 1'b1;
                    end
`endif
                end
`ifdef ADC_SPI_BURST_EN
                S_BURST: begin
                    if (cs_s) begin
                        state <= S_IDLE;
                    end else begin
                        if (sck_rise) begin
                            if (wcnt == WW'(DATA_W - 1)) begin
                                wcnt <= '0;
                                wend <= 1'b1;
                            end else begin
                                wcnt <= wcnt + WW'(1);
                            end
                        end
                        if (sck_fall && wend) begin
                            wend <= 1'b0;
                            bch  <= nxt;
                            mbuf <= data_r[nxt];
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] ctrl_nx;
    logic [NUM_CH-1:0] clr_eoc;
    logic [NUM_CH-1:0] clr_ovr;

    always_comb begin
        ctrl_nx = ctrl_r;
        clr_eoc = burst_clr;
        clr_ovr = '0;
        if (in_latch) begin
            if (lat_addr == ADDR_W'(0)) begin
                case (lat_cmd)
                    CMD_WR:  ctrl_nx = lat_pay;
                    CMD_SET: ctrl_nx = ctrl_r | lat_pay;
                    CMD_CLR: ctrl_nx = ctrl_r & ~lat_pay;
                    default: ctrl_nx = ctrl_r;
                endcase
            end
            if (lat_cmd == CMD_RD) begin
                if (lat_is_data)
                    clr_eoc[rd_ch] = 1'b1;
                if (lat_addr == ADDR_W'(1))
                    clr_eoc = clr_eoc | eoc_sent;
            end
            if (lat_cmd == CMD_CLR && lat_addr == ADDR_W'(1))
                clr_ovr = lat_pay[2*NUM_CH-1:NUM_CH];
        end
        // hardware start acknowledge wins over any SPI write of that bit
        for (int c = 0; c < NUM_CH; c++)
            if (hw_clear_start[c])
                ctrl_nx[1 + c] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ctrl_r <= '0;
            eoc_r  <= '0;
            ovr_r  <= '0;
            for (int c = 0; c < NUM_CH; c++)
                data_r[c] <= '0;
        end else begin
            ctrl_r <= ctrl_nx;
            for (int c = 0; c < NUM_CH; c++) begin
                if (eoc_rise[c])
                    data_r[c] <= adc_data_in[c*DATA_W +: DATA_W];
                if (hw_clear_start[c])
                    eoc_r[c] <= 1'b0;
                else if (eoc_rise[c])
                    eoc_r[c] <= 1'b1;
                else if (clr_eoc[c])
                    eoc_r[c] <= 1'b0;
                if (!hw_clear_start[c] && eoc_rise[c] && eoc_r[c])
                    ovr_r[c] <= 1'b1;
                else if (clr_ovr[c])
                    ovr_r[c] <= 1'b0;
            end
        end
    end

    assign miso         = cs ? 1'bz : mbuf[DATA_W-1];
    assign ctrl_reg_out = ctrl_r;
    assign eoc_flag_out = eoc_r;
    assign overrun_out  = ovr_r;
    assign irq_out      = ctrl_r[0] & (|eoc_r);

endmodule

// File: tb/tb_adc_spi_slave_mc.sv
// tb_adc_spi_slave_mc: directed and randomized bench for adc_spi_slave_mc
// against an operation-level register model.
module tb_adc_spi_slave_mc;
    localparam int DW   = 12;
    localparam int NC   = 4;
    localparam int AW   = 4;
    localparam int F    = 2 + AW + DW;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    logic cs = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    wire  miso;
    logic [NC*DW-1:0] adc_data_in = '0;
    logic [NC-1:0]    adc_busy_in = '0;
    logic [NC-1:0]    adc_eoc_pulse = '0;
    logic [NC-1:0]    hw_clear_start = '0;
    logic [DW-1:0]    ctrl_reg_out;
    logic [NC-1:0]    eoc_flag_out;
    logic [NC-1:0]    overrun_out;
    logic             irq_out;

    always #5 clk = ~clk;

    adc_spi_slave_mc #(
        .DATA_W (DW),
        .NUM_CH (NC),
        .ADDR_W (AW),
        .INFO_ID(8'h0B)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .cs            (cs),
        .sck           (sck),
        .mosi          (mosi),
        .miso          (miso),
        .adc_data_in   (adc_data_in),
        .adc_busy_in   (adc_busy_in),
        .adc_eoc_pulse (adc_eoc_pulse),
        .hw_clear_start(hw_clear_start),
        .ctrl_reg_out  (ctrl_reg_out),
        .eoc_flag_out  (eoc_flag_out),
        .overrun_out   (overrun_out),
        .irq_out       (irq_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_ctrl = '0;
    logic [NC-1:0] m_eoc = '0;
    logic [NC-1:0] m_ovr = '0;
    logic [DW-1:0] m_data [NC];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read_val(input int a);
        logic [DW-1:0] v;
        v = '0;
        if (a == 0)
            v = m_ctrl;
        else if (a == 1)
            v = DW'({m_ovr, m_eoc});
        else if (a == 2)
            v = DW'(adc_busy_in);
        else if (a == 3)
            v = DW'((NC << 8) | 8'h0B);
        else if (a >= 4 && a < 4 + NC)
            v = m_data[a - 4];
        return v;
    endfunction

    task automatic m_frame(input logic [1:0] cmd, input int a,
                           input logic [DW-1:0] pay);
        if (cmd == 2'b00) begin
            if (a == 1)
                m_eoc = '0;
            else if (a >= 4 && a < 4 + NC)
                m_eoc[a - 4] = 1'b0;
        end else if (a == 0) begin
            if (cmd == 2'b01)
                m_ctrl = pay;
            else if (cmd == 2'b10)
                m_ctrl = m_ctrl | pay;
            else
                m_ctrl = m_ctrl & ~pay;
        end else if (a == 1 && cmd == 2'b11) begin
            m_ovr = m_ovr & ~pay[2*NC-1:NC];
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "/ctrl"}, 32'(ctrl_reg_out), 32'(m_ctrl));
        check({tag, "/eoc"}, 32'(eoc_flag_out), 32'(m_eoc));
        check({tag, "/ovr"}, 32'(overrun_out), 32'(m_ovr));
        check({tag, "/irq"}, 32'(irq_out), 32'(m_ctrl[0] & (|m_eoc)));
    endtask

    task automatic spi_xfer(input logic [1:0] cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] pay, input int nbits,
                            output logic [63:0] rx);
        logic [F-1:0] tx;
        tx = {cmd, addr, pay};
        rx = '0;
        @(negedge clk) cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < F) ? tx[F-1-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            rx = {rx[62:0], (miso === 1'b1)};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [1:0] cmd, input int a,
                         input logic [DW-1:0] pay, input string tag);
        logic [63:0]   rx;
        logic [DW-1:0] exp;
        exp = m_read_val(a);
        spi_xfer(cmd, AW'(a), pay, F, rx);
        if (cmd == 2'b00)
            check({tag, "/rd"}, 32'(rx[DW-1:0]), 32'(exp));
        m_frame(cmd, a, pay);
        check_outs(tag);
    endtask

    task automatic eoc_pulse(input int ch, input logic [DW-1:0] val);
        adc_data_in[ch*DW +: DW] = val;
        @(negedge clk) adc_eoc_pulse[ch] = 1'b1;
        repeat (3) @(negedge clk);
        adc_eoc_pulse[ch] = 1'b0;
        repeat (4) @(negedge clk);
        m_data[ch] = val;
        if (m_eoc[ch])
            m_ovr[ch] = 1'b1;
        m_eoc[ch] = 1'b1;
    endtask

    initial begin
        #2ms;
        n_err++;
        $display("FAIL timeout: run did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [63:0]   rx;
        logic [DW-1:0] d [NC];
        logic [1:0]    cmd;
        logic [DW-1:0] pay;
        int            op, ch, a, nb;

        for (int c = 0; c < NC; c++)
            m_data[c] = '0;

        repeat (3) @(negedge clk);
        check_outs("reset");
        reset_ = 1'b1;
        repeat (3) @(negedge clk);

        // INFO readback
        spi_xfer(2'b00, 4'd3, '0, F, rx);
        check("info", 32'(rx[DW-1:0]), 32'h40B);
        check_outs("info");

        // channel 2 eoc latency and data read
        adc_data_in[2*DW +: DW] = 12'hA5C;
        @(negedge clk) adc_eoc_pulse[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("eoc_lat2", 32'(eoc_flag_out), 32'h0);
        @(negedge clk);
        check("eoc_lat3", 32'(eoc_flag_out), 32'h4);
        adc_eoc_pulse[2] = 1'b0;
        repeat (4) @(negedge clk);
        m_data[2] = 12'hA5C;
        m_eoc[2] = 1'b1;
        check_outs("eoc2");
        frame(2'b01, 0, 12'h001, "irq_en");
        frame(2'b00, 6, '0, "rd_ch2");

        // overrun on channel 1
        eoc_pulse(1, 12'h111);
        eoc_pulse(1, 12'h222);
        check_outs("ovr1");
        frame(2'b00, 1, '0, "rd_status");
        frame(2'b11, 1, 12'h020, "clr_ovr");

        // hw_clear_start on the same clk as the synchronised eoc rise
        frame(2'b01, 0, 12'h003, "ctrl3");
        @(negedge clk) adc_eoc_pulse[0] = 1'b1;
        @(negedge clk);
        @(negedge clk) hw_clear_start[0] = 1'b1;
        @(negedge clk) hw_clear_start[0] = 1'b0;
        repeat (2) @(negedge clk);
        adc_eoc_pulse[0] = 1'b0;
        repeat (4) @(negedge clk);
        m_eoc[0] = 1'b0;
        m_ctrl[1] = 1'b0;
        check_outs("hwclr_eoc");

        // SET CTRL while hw_clear_start[0] covers the LATCH cycle
        frame(2'b01, 0, 12'h000, "ctrl0");
        hw_clear_start[0] = 1'b1;
        spi_xfer(2'b10, 4'd0, 12'h003, F, rx);
        hw_clear_start[0] = 1'b0;
        m_ctrl = 12'h003;
        m_ctrl[1] = 1'b0;
        m_eoc[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("hwclr_set");

        // aborted WRITE then a normal frame
        eoc_pulse(3, 12'h3C3);
        spi_xfer(2'b01, 4'd0, 12'hFFF, 10, rx);
        check_outs("abort");
        frame(2'b01, 0, 12'h0F0, "post_abort");
        frame(2'b01, 0, 12'h001, "ctrl1");

        // DATA read of channel 3 held for three extra words
        for (int c = 0; c < NC; c++) begin
            d[c] = DW'($urandom_range(1, 4095));
            eoc_pulse(c, d[c]);
        end
        check_outs("burst_pre");
        spi_xfer(2'b00, 4'd7, '0, F + 3*DW, rx);
        check("burst_w0", 32'(rx[4*DW-1 -: DW]), 32'(d[3]));
`ifdef ADC_SPI_BURST_EN
        check("burst_w1", 32'(rx[3*DW-1 -: DW]), 32'(d[0]));
        check("burst_w2", 32'(rx[2*DW-1 -: DW]), 32'(d[1]));
        check("burst_w3", 32'(rx[DW-1:0]), 32'(d[2]));
        m_eoc = '0;
`else
        check("burst_w1", 32'(rx[3*DW-1 -: DW]), 32'h0);
        check("burst_w2", 32'(rx[2*DW-1 -: DW]), 32'h0);
        check("burst_w3", 32'(rx[DW-1:0]), 32'h0);
        m_eoc[3] = 1'b0;
`endif
        check_outs("burst");

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            ch = $urandom_range(0, NC - 1);
            a  = $urandom_range(0, 15);
            cmd = 2'($urandom_range(0, 3));
            pay = DW'($urandom);
            case (op)
                0: begin
                    eoc_pulse(ch, DW'($urandom));
                    check_outs("r_eoc");
                end
                1: frame(cmd, a, pay, "r_frame");
                2: begin
                    @(negedge clk) hw_clear_start[ch] = 1'b1;
                    @(negedge clk) hw_clear_start[ch] = 1'b0;
                    m_eoc[ch] = 1'b0;
                    m_ctrl[1 + ch] = 1'b0;
                    check_outs("r_hwclr");
                end
                3: begin
                    nb = $urandom_range(1, F - 1);
                    spi_xfer(cmd, AW'(a), pay, nb, rx);
                    check_outs("r_abort");
                end
                default: begin
                    adc_busy_in = NC'($urandom);
                    frame(2'b00, 2, '0, "r_busy");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
